// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder/subtractor controller.
// State encodings are plain constants so older tools can consume them.
package serial_add_pkg;

  localparam int unsigned DefaultWidth = 8;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

endpackage

// File: rtl/fa_cell.sv
// Combinational one-bit full adder; the only arithmetic in the serial datapath.
module fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract: one fa_cell stepped LSB-first over WIDTH cycles.
// Results are published on the edge entering DONE and held until the next DONE.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             cell_s, cell_co;
  logic             load;
  logic [WIDTH-1:0] res_shift;

  fa_cell u_fa_cell (
    .x  (opa_q[0]),
    .y  (opb_q[0]),
    .ci (carry_q),
    .s  (cell_s),
    .co (cell_co)
  );

  // A new operation can launch from IDLE or straight out of DONE.
  assign load      = start && ((state_q == StIdle) || (state_q == StDone));
  assign res_shift = {cell_s, res_q[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (load) begin
          // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
          opa_d   = a;
          opb_d   = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          res_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        res_d   = res_shift;
        carry_d = cell_co;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          // carry_q here is the carry into the MSB.
          sum_d   = res_shift;
          cout_d  = cell_co;
          ovf_d   = carry_q ^ cell_co;
          cnt_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy     = (state_q == StRun);
  assign done     = (state_q == StDone);
  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl at WIDTH=8 with hand-computed results.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       busy, done, cout, overflow;
  logic [7:0] sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(
    .WIDTH (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .sub      (sub),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation and check latency, results and the idle cycle after.
  // pulse_at > 0 drives a stray start with other operands at that RUN cycle.
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic isub, input logic [7:0] es, input logic ec,
                        input logic eo, input int pulse_at);
    int lat = 0;
    @(negedge clk);
    a = ia; b = ib; sub = isub; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == pulse_at) begin
        a = 8'h77; b = 8'h77; sub = 1'b0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
    check_eq({tag, "_lat"}, lat, 8);
    check_eq({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    check_eq({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
    check_eq({tag, "_ovf"}, {31'd0, overflow}, {31'd0, eo});
    check_eq({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq({tag, "_idle_after"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    int d1, d2, overlap, done_seen;

    #1;
    check_eq("reset_outs", {21'd0, busy, done, sum, cout, overflow}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    repeat (5) @(negedge clk);
    check_eq("hold_idle", {22'd0, busy, done, sum}, 32'd0);

    run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1, 0);

    // Stray start at RUN cycle 3 must not queue or alter the operation.
    run_op("ignore_start", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 3);

    // start held high: two back-to-back operations.
    d1 = 0; d2 = 0; overlap = 0;
    @(negedge clk);
    a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      if (i == 0) begin
        a = 8'h03; b = 8'h04;
      end
      if (busy == done) overlap++;
      if (done && d1 == 0) begin
        d1 = i;
        check_eq("b2b_sum1", {24'd0, sum}, 32'h03);
      end else if (done) begin
        d2 = i;
        check_eq("b2b_sum2", {24'd0, sum}, 32'h07);
        start = 1'b0;
        break;
      end
    end
    check_eq("b2b_first_lat", d1, 8);
    check_eq("b2b_spacing", d2 - d1, 9);
    check_eq("b2b_busy_xor_done", overlap, 0);

    // Reset in RUN cycle 4 clears everything immediately.
    @(negedge clk);
    a = 8'h55; b = 8'h0F; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_outs", {21'd0, busy, done, sum, cout, overflow}, 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done || busy) done_seen++;
    end
    check_eq("rst_quiet", done_seen, 0);
    rst_n = 1'b1;
    run_op("post_rst", 8'hC8, 8'h64, 1'b0, 8'h2C, 1'b1, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
